// File: rtl/mdu_exec.sv
// rtl/mdu_exec.sv - Iterative multiply/divide unit for the execute stage.
// Shift-add multiplier and restoring divider, one bit per clock, sign fix in a final cycle.
module mdu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             is_div, sa, sb, dz;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo, orig_a;

  logic             sa_in, sb_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // op[0]=0 selects the signed variants (MULT, DIV)
  assign sa_in = ~op[0] & a[WIDTH-1];
  assign sb_in = ~op[0] & b[WIDTH-1];
  assign mag_a = sa_in ? -a : a;
  assign mag_b = sb_in ? -b : b;

  // Multiply: acc_hi holds the running upper half, acc_lo the multiplier being shifted out
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo the dividend/quotient shift register
  assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, opnd};
  assign rem_sub = rem_sh[WIDTH-1:0] - opnd;

  assign prod_fix = (sa ^ sb) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = (sa ^ sb) ? -acc_lo : acc_lo;
  assign rem_fix  = sa ? -acc_hi : acc_hi;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      orig_a <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= op[1];
            sa     <= sa_in;
            sb     <= sb_in;
            orig_a <= a;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op[1] ? mag_a : mag_b;
            opnd   <= op[1] ? mag_b : mag_a;
            if (op[1] && (b == '0)) begin
              dz    <= 1'b1;
              state <= S_FIX;
            end else begin
              dz    <= 1'b0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          done  <= 1'b1;
          state <= S_IDLE;
          if (dz) begin
            hi <= orig_a;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_exec.sv
// tb/tb_mdu_exec.sv - Randomized self-checking bench for mdu_exec.
// Results come from a plain-arithmetic reference model; latency, busy and hold behaviour are checked too.
module tb_mdu_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic [W-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  always #5 clk = ~clk;

  mdu_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return sx * sy;
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge where done is seen (or post-checks one more).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke, input bit post);
    logic [63:0] exp;
    int k, bcnt, exp_lat;
    bit hold_ok;
    exp = ref_model(o, x, y);
    exp_lat = (o[1] && y == 0) ? 1 : 33;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    k = 0; bcnt = 0; hold_ok = 1'b1;
    while (!done && k < 60) begin
      if (busy) bcnt++;
      if (hi !== last_hi || lo !== last_lo) hold_ok = 1'b0;
      start = poke && (k == 10);
      if (start) begin
        op = 2'd1; a = $urandom; b = $urandom;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("latency", 64'(k), 64'(exp_lat));
    check("busy_cycles", 64'(bcnt), 64'(exp_lat));
    check("hold", 64'(hold_ok), 64'd1);
    check("result", {hi, lo}, exp);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    if (post) begin
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2'd0, 32'hFFFFFFFD, 32'd7, 0, 1);
    check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(2'd0, 32'h80000000, 32'h80000000, 0, 1);
    check("mult_min", {hi, lo}, 64'h40000000_00000000);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 1);
    check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd3, 32'd100, 32'd7, 0, 1);
    check("divu", {hi, lo}, 64'h00000002_0000000E);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);
    run_op(2'd3, 32'h1234, 32'd0, 0, 1);
    check("div_zero", {hi, lo}, 64'h00001234_FFFFFFFF);

    // start while busy is ignored; start in the done cycle is accepted
    run_op(2'd1, 32'h00012345, 32'h00000678, 1, 0);
    run_op(2'd3, 32'hDEADBEEF, 32'h00000013, 0, 1);

    // asynchronous reset mid-divide
    start = 1'b1; op = 2'd2; a = 32'hFFFFFFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    last_hi = '0; last_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd2, 32'hFFFFFF9C, 32'd7, 0, 1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = specials[$urandom_range(0, 4)];
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, (i % 7) == 3, (i % 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
